// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers; optional stall counter under FIFO_ARB_STALL_CNT_EN
module fifo_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      wr,
  output logic [DATA_W-1:0]         wdata,
`ifdef FIFO_ARB_STALL_CNT_EN
  input  logic                      stall_clr,
  output logic [15:0]               stall_cnt,
`endif
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0]    state;
  logic [IW-1:0] rr_ptr, win_idx, winner;
  logic          found, grant;
  int            idx;
  // cyclic first-set search starting at rr_ptr
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end
  assign grant = (state == IDLE) && found && !fifo_full;
  assign wr    = (state == ISSUE);
  assign busy  = wr;
  assign ack   = wr ? (NUM_REQ'(1) << win_idx) : '0;
  // two-state FSM: latch winner and its sample in IDLE, advance pointer in ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      win_idx <= '0;
      wdata   <= '0;
    end else if (state == IDLE) begin
      if (grant) begin
        wdata   <= req_data[winner*DATA_W +: DATA_W];
        win_idx <= winner;
        state   <= ISSUE;
      end
    end else begin
      rr_ptr <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      state  <= IDLE;
    end
  end
`ifdef FIFO_ARB_STALL_CNT_EN
  // saturating count of IDLE cycles blocked by a full FIFO
  always_ff @(posedge clk) begin
    if (rst || stall_clr)
      stall_cnt <= '0;
    else if (state == IDLE && |req && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
